// File: rtl/conv_1x1_ofm_writeback.sv
// rtl/conv_1x1_ofm_writeback.sv - requantize four PE psums to int8, pack, and write OFM words via a small FIFO
// Optional feature macro RELU_EN: negative psums are clamped to 0 before requantization.
module conv_1x1_ofm_writeback #(
  parameter int PSUM_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cal_start,
  input  logic [7:0]          num_filter,
  input  logic [15:0]         num_pixel,
  input  logic [4:0]          shift,
  input  logic [3:0]          PE_finish,
  input  logic [4*PSUM_W-1:0] pe_psum,
  input  logic                ofm_wr_ready,
  output logic                ofm_wr_en,
  output logic [31:0]         ofm_wr_addr,
  output logic [31:0]         ofm_wr_data,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                finish_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic signed [PSUM_W:0] Q_MAX = (PSUM_W+1)'(127);
  localparam logic signed [PSUM_W:0] Q_MIN = -(PSUM_W+1)'(128);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [23:0]   word_cnt;
  logic [23:0]   target;
  logic [31:0]   addr;
  logic [31:0]   packed_word;
  logic          fifo_empty;
  logic          fifo_full;
  logic          start;
  logic          pop;
  logic          capture;
  logic          push;

  // Rounding add is done one bit wider than the psum so it cannot wrap.
  function automatic logic [7:0] requant(input logic signed [PSUM_W-1:0] p, input logic [4:0] s);
    logic signed [PSUM_W:0] ext;
    logic signed [PSUM_W:0] rnd;
    logic signed [PSUM_W:0] r;
    ext = {p[PSUM_W-1], p};
`ifdef RELU_EN
    if (p[PSUM_W-1]) ext = '0;
`endif
    rnd = '0;
    if (s != 5'd0) rnd = $signed((PSUM_W+1)'(1) << (s - 5'd1));
    r = (ext + rnd) >>> s;
    if (r > Q_MAX)      return 8'h7f;
    else if (r < Q_MIN) return 8'h80;
    else                return r[7:0];
  endfunction

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < 4; i++)
      packed_word[8*i +: 8] = requant(pe_psum[PSUM_W*i +: PSUM_W], shift);
  end

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == (PW+1)'(FIFO_DEPTH));
  assign start       = (state == IDLE) && cal_start;
  assign pop         = !fifo_empty && ofm_wr_ready;
  assign capture     = (state == RUN) && (PE_finish == 4'hf);
  assign push        = capture && (!fifo_full || pop);
  assign ofm_wr_en   = !fifo_empty;
  assign ofm_wr_addr = addr;
  assign ofm_wr_data = fifo_empty ? 32'h0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= packed_word;
  end

  // FIFO pointers plus the address/count of the word at the FIFO head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
      addr     <= '0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
      addr     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        word_cnt <= word_cnt + 24'd1;
        addr     <= addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      target     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      finish_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cal_start) begin
            state      <= RUN;
            busy       <= 1'b1;
            overflow   <= 1'b0;
            finish_err <= 1'b0;
            target     <= (24'(num_pixel) * 24'(num_filter)) >> 2;
          end
        end
        RUN: begin
          if ((PE_finish != 4'h0) && (PE_finish != 4'hf)) finish_err <= 1'b1;
          if (capture && !push) overflow <= 1'b1;
          if (pop && (word_cnt + 24'd1 == target)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_1x1_ofm_writeback.sv
// tb/tb_conv_1x1_ofm_writeback.sv - scoreboard bench: stimulus pushes expected words, monitor pops and compares
// Honours RELU_EN in its reference model the same way the design does.
module tb_conv_1x1_ofm_writeback;
  localparam int PSUM_W = 32;
  localparam int DEPTH  = 2;

  logic                clk;
  logic                reset_n;
  logic                cal_start;
  logic [7:0]          num_filter;
  logic [15:0]         num_pixel;
  logic [4:0]          shift;
  logic [3:0]          PE_finish;
  logic [4*PSUM_W-1:0] pe_psum;
  logic                ofm_wr_ready;
  logic                ofm_wr_en;
  logic [31:0]         ofm_wr_addr;
  logic [31:0]         ofm_wr_data;
  logic                busy;
  logic                done;
  logic                overflow;
  logic                finish_err;

  conv_1x1_ofm_writeback dut (
    .clk(clk), .reset_n(reset_n), .cal_start(cal_start), .num_filter(num_filter),
    .num_pixel(num_pixel), .shift(shift), .PE_finish(PE_finish), .pe_psum(pe_psum),
    .ofm_wr_ready(ofm_wr_ready), .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr),
    .ofm_wr_data(ofm_wr_data), .busy(busy), .done(done), .overflow(overflow),
    .finish_err(finish_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stimulus-owned state
  logic [31:0] exp_q [$];
  int          target;
  int          layers_started;
  int          pushes;
  int          timeouts;
  bit          exp_ovf;
  bit          exp_ferr;
  bit          chk_en;
  bit          rst_chk;
  bit          end_req;
  int          p [4];

  // monitor-owned state
  int          acc;
  int          layers_done;
  bit          done_pending;
  bit          exp_done;
  int          n_checks;
  int          n_pass;

  function automatic logic [7:0] q_ref(input longint p_in, input int s);
    longint v, n, d, r;
    v = p_in;
`ifdef RELU_EN
    if (v < 0) v = 0;
`endif
    if (s == 0) r = v;
    else begin
      d = longint'(1) << s;
      n = v + d / 2;
      r = n / d;
      if ((n % d != 0) && (n < 0)) r = r - 1;
    end
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic int rand_psum();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom);
      2:       return int'(32'h7fffffff);
      3:       return int'(32'h80000000);
      default: return int'($urandom_range(0, 40000)) - 20000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  task automatic set_p(input int a0, input int a1, input int a2, input int a3);
    p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3;
  endtask

  task automatic rand_p();
    for (int i = 0; i < 4; i++) p[i] = rand_psum();
  endtask

  // Drive one cycle; decide what the buffer should do at the coming edge, commit it after the edge.
  task automatic cycle(input bit cs, input logic [3:0] fin, input bit rdy);
    bit idle, run, st, pu, ov, fe, popn;
    logic [31:0] w;
    idle = (layers_started == layers_done) && !done_pending;
    run  = (layers_started != layers_done) && !done_pending;
    cal_start    = cs;
    PE_finish    = fin;
    ofm_wr_ready = rdy;
    pe_psum      = {p[3], p[2], p[1], p[0]};
    st = 0; pu = 0; ov = 0; fe = 0; w = '0;
    if (cs && idle) st = 1;
    if (run) begin
      if (fin == 4'hf) begin
        popn = (exp_q.size() > 0) && rdy;
        if ((exp_q.size() < DEPTH) || popn) begin
          pu = 1;
          w  = {q_ref(p[3], int'(shift)), q_ref(p[2], int'(shift)),
                q_ref(p[1], int'(shift)), q_ref(p[0], int'(shift))};
        end else ov = 1;
      end else if (fin != 4'h0) fe = 1;
    end
    @(posedge clk);
    #1;
    if (st) begin
      exp_q.delete();
      exp_ovf  = 0;
      exp_ferr = 0;
      pushes   = 0;
      layers_started++;
    end
    if (pu) begin
      exp_q.push_back(w);
      pushes++;
    end
    if (ov) exp_ovf = 1;
    if (fe) exp_ferr = 1;
    cal_start = 1'b0;
    PE_finish = 4'h0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!((layers_started == layers_done) && !done_pending) && g < 100) begin
      cycle(0, 4'h0, 1);
      g++;
    end
    if (g >= 100) timeouts++;
  endtask

  task automatic start_layer(input int nf, input int np, input int s);
    wait_idle();
    num_filter = 8'(nf);
    num_pixel  = 16'(np);
    shift      = 5'(s);
    target     = np * nf / 4;
    cycle(1, 4'h0, 1);
  endtask

  initial begin
    acc = 0; layers_done = 0; done_pending = 0; exp_done = 0; n_checks = 0; n_pass = 0;
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_layers_done", 32'(layers_done), 32'(layers_started));
        chk("timeouts", 32'(timeouts), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
      if (rst_chk) begin
        chk("rst_wr_en", 32'(ofm_wr_en), 32'd0);
        chk("rst_wr_addr", ofm_wr_addr, 32'd0);
        chk("rst_wr_data", ofm_wr_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_finish_err", 32'(finish_err), 32'd0);
      end
      if (!chk_en) begin
        acc = 0;
        done_pending = 0;
      end else begin
        exp_done = done_pending;
        done_pending = 0;
        if (exp_done) layers_done++;
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(layers_started != layers_done));
        chk("wr_en", 32'(ofm_wr_en), 32'(exp_q.size() != 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("finish_err", 32'(finish_err), 32'(exp_ferr));
        if (ofm_wr_en && exp_q.size() != 0) begin
          chk("wr_data", ofm_wr_data, exp_q[0]);
          chk("wr_addr", ofm_wr_addr, 32'(acc * 4));
          if (ofm_wr_ready) begin
            void'(exp_q.pop_front());
            acc++;
            if (acc == target) begin
              done_pending = 1;
              acc = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int nf, np, s, g;
    logic [3:0] fin;
    reset_n = 1'b0; cal_start = 1'b0; num_filter = 8'd4; num_pixel = 16'd1; shift = 5'd0;
    PE_finish = 4'h0; pe_psum = '0; ofm_wr_ready = 1'b0;
    layers_started = 0; pushes = 0; timeouts = 0; target = 1;
    exp_ovf = 0; exp_ferr = 0; chk_en = 0; rst_chk = 1; end_req = 0;
    set_p(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1; rst_chk = 0; chk_en = 1;

    // single word, shift 0, mixed signs
    start_layer(4, 1, 0);
    set_p(0, -2, 1, 3);
    cycle(0, 4'hf, 1);
    wait_idle();

    // rounding shift, then saturation at shift 0
    start_layer(4, 2, 4);
    set_p(-8, 8, -1000, 1000);
    cycle(0, 4'hf, 1);
    shift = 5'd0;
    set_p(-5000, 5000, -129, 128);
    cycle(0, 4'hf, 1);
    wait_idle();

    // four back-to-back words
    start_layer(8, 2, 3);
    for (int i = 0; i < 4; i++) begin
      rand_p();
      cycle(0, 4'hf, 1);
    end
    wait_idle();

    // backpressure: two held, third dropped, then release
    start_layer(4, 3, 2);
    for (int i = 0; i < 3; i++) begin
      rand_p();
      cycle(0, 4'hf, 0);
    end
    repeat (3) cycle(0, 4'h0, 0);
    repeat (2) cycle(0, 4'h0, 1);
    rand_p();
    cycle(0, 4'hf, 1);
    wait_idle();

    // malformed PE_finish, then reset mid-layer with a word pending
    start_layer(4, 1, 0);
    cycle(0, 4'b0011, 1);
    rand_p();
    cycle(0, 4'hf, 0);
    cycle(0, 4'h0, 0);
    chk_en = 0; rst_chk = 1; reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_ovf = 0; exp_ferr = 0;
    layers_started = layers_done;
    reset_n = 1'b1; rst_chk = 0; chk_en = 1;
    cycle(0, 4'h0, 1);

    // randomized layers
    for (int l = 0; l < 12; l++) begin
      nf = 4 * int'($urandom_range(1, 3));
      np = int'($urandom_range(1, 4));
      s  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      start_layer(nf, np, s);
      g = 0;
      while (pushes < target && g < 400) begin
        rand_p();
        case ($urandom_range(0, 19))
          0:       fin = 4'($urandom_range(1, 14));
          1, 2, 3, 4, 5, 6, 7, 8, 9: fin = 4'hf;
          default: fin = 4'h0;
        endcase
        cycle(0, fin, $urandom_range(0, 3) != 0);
        g++;
      end
      if (g >= 400) timeouts++;
      wait_idle();
    end

    end_req = 1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor_end: summary not reached");
    $fatal(1);
  end

endmodule
